// File: rtl/expr_equiv_checker_pkg.sv
// eqchk_pkg: shared FSM state type and default parameters for expr_equiv_checker.
package eqchk_pkg;
    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;
    localparam int N_IN_DEF   = 2;
    localparam int SETTLE_DEF = 1;
endpackage

// File: rtl/expr_equiv_checker_vec_sequencer.sv
// vec_sequencer: walks the input vector and times the settle window before each sample.
import eqchk_pkg::*;
module vec_sequencer #(
    parameter int N_IN   = N_IN_DEF,
    parameter int SETTLE = SETTLE_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic            settling,
    input  logic            sampling,
    output logic [N_IN-1:0] x_vec,
    output logic            sample_pulse,
    output logic            last_vec
);
    localparam int CW = SETTLE > 1 ? $clog2(SETTLE) : 1;
    logic [CW-1:0] cnt;
    assign sample_pulse = settling && cnt == '0;
    assign last_vec     = &x_vec;
    // The last vector is never incremented, so x_vec holds its final value into DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            x_vec <= '0;
            cnt   <= '0;
        end else if (load) begin
            x_vec <= '0;
            cnt   <= CW'(SETTLE - 1);
        end else if (settling && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end else if (sampling && !last_vec) begin
            x_vec <= x_vec + 1'b1;
            cnt   <= CW'(SETTLE - 1);
        end
    end
endmodule

// File: rtl/expr_equiv_checker.sv
// expr_equiv_checker: exhaustively drives a 2-input expression pair and compares s1 with s2.
// Define EQUIV_XCHECK_EN to also count X/Z on s1/s2 as a mismatch (simulation only).
import eqchk_pkg::*;
module expr_equiv_checker #(
    parameter int N_IN   = N_IN_DEF,
    parameter int SETTLE = SETTLE_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    output logic [N_IN-1:0] x_vec,
    input  logic            s1,
    input  logic            s2,
    output logic            busy,
    output logic            done,
    output logic            equiv,
    output logic [N_IN:0]   mismatch_cnt,
    output logic [N_IN-1:0] first_bad,
    output logic            first_bad_valid
);
    localparam logic [N_IN:0] MAX_CNT = (N_IN + 1)'(1) << N_IN;
    state_t state, state_nx;
    logic load, diff, sample_pulse, last_vec;
    assign load = start && (state == IDLE || state == DONE);
    vec_sequencer #(.N_IN(N_IN), .SETTLE(SETTLE)) u_seq (
        .clk         (clk),
        .reset       (reset),
        .load        (load),
        .settling    (state == eqchk_pkg::SETTLE),
        .sampling    (state == SAMPLE),
        .x_vec       (x_vec),
        .sample_pulse(sample_pulse),
        .last_vec    (last_vec)
    );
`ifdef EQUIV_XCHECK_EN
    always_comb diff = $isunknown({s1, s2}) || (s1 !== s2);
`else
    always_comb diff = s1 != s2;
`endif
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end
    always_comb begin
        state_nx = load ? eqchk_pkg::SETTLE :
                   (state == eqchk_pkg::SETTLE && sample_pulse) ? SAMPLE :
                   (state == SAMPLE) ? (last_vec ? DONE : eqchk_pkg::SETTLE) : state;
    end
    always_comb begin
        busy  = state == eqchk_pkg::SETTLE || state == SAMPLE;
        done  = state == DONE;
        equiv = done && mismatch_cnt == '0;
    end
    always_ff @(posedge clk) begin
        if (reset || load) begin
            mismatch_cnt    <= '0;
            first_bad       <= '0;
            first_bad_valid <= 1'b0;
        end else if (state == SAMPLE && diff) begin
            if (mismatch_cnt != MAX_CNT) mismatch_cnt <= mismatch_cnt + 1'b1;
            if (!first_bad_valid) begin
                first_bad       <= x_vec;
                first_bad_valid <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_expr_equiv_checker.sv
// tb_expr_equiv_checker: directed runs on SETTLE=1 and SETTLE=3 instances against a run-level model.
module tb_expr_equiv_checker;
    logic clk = 0, reset = 1, start0 = 0, start3 = 0;
    int mode = 0;
    logic [1:0] xv0, xv3, fb0, fb3;
    logic [2:0] mc0, mc3;
    logic s1a, s2a, s1b, s2b;
    logic busy0, done0, eq0, fbv0, busy3, done3, eq3, fbv3;
    int tests = 0, fails = 0;
    bit chk_en = 0;
    bit run0 = 0, run3 = 0;
    int t0 = 0, t3 = 0, m0 = 0, m3 = 0;
    always #5 clk = ~clk;

    function automatic logic [1:0] expr(int m, logic [1:0] v);
        logic x, y;
        x = v[1];
        y = v[0];
        case (m)
            0: return {x & ~(~x | ~y), x & y};
            1: return {x & y, x | y};
            2: return 2'b10;
            default: return {(v == 2'd2) ? 1'bx : (x & y), x & y};
        endcase
    endfunction

    // Truth-table level: which vectors disagree for each expression pair.
    function automatic bit mism(int m, int v);
        case (m)
            0: return 0;
            1: return v == 1 || v == 2;
            2: return 1;
            default: return v == 2;
        endcase
    endfunction

    function automatic void model(input int s, input bit run, input int t, input int m,
                                  output int xv, output int bz, output int dn,
                                  output int mc, output int fb, output int fbv);
        int per, comp;
        per = s + 1;
        xv = 0; bz = 0; dn = 0; mc = 0; fb = 0; fbv = 0;
        if (run) begin
            bz = (t < 4 * per) ? 1 : 0;
            dn = 1 - bz;
            xv = (t / per > 3) ? 3 : t / per;
            comp = (t / per > 4) ? 4 : t / per;
            for (int v = 0; v < comp; v++)
                if (mism(m, v)) begin
                    if (fbv == 0) begin fb = v; fbv = 1; end
                    mc++;
                end
        end
    endfunction

    always_comb {s1a, s2a} = expr(mode, xv0);
    always_comb {s1b, s2b} = expr(mode, xv3);

    expr_equiv_checker dut (
        .clk(clk), .reset(reset), .start(start0), .x_vec(xv0), .s1(s1a), .s2(s2a),
        .busy(busy0), .done(done0), .equiv(eq0), .mismatch_cnt(mc0),
        .first_bad(fb0), .first_bad_valid(fbv0)
    );
    expr_equiv_checker #(.N_IN(2), .SETTLE(3)) dut3 (
        .clk(clk), .reset(reset), .start(start3), .x_vec(xv3), .s1(s1b), .s2(s2b),
        .busy(busy3), .done(done3), .equiv(eq3), .mismatch_cnt(mc3),
        .first_bad(fb3), .first_bad_valid(fbv3)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (reset) run0 <= 0;
        else if (start0 && !(run0 && t0 < 8)) begin run0 <= 1; t0 <= 0; m0 <= mode; end
        else if (run0 && t0 < 1000) t0 <= t0 + 1;
        if (reset) run3 <= 0;
        else if (start3 && !(run3 && t3 < 16)) begin run3 <= 1; t3 <= 0; m3 <= mode; end
        else if (run3 && t3 < 1000) t3 <= t3 + 1;
    end

    always @(negedge clk) begin
        int xv, bz, dn, mc, fb, fbv;
        if (chk_en) begin
            model(1, run0, t0, m0, xv, bz, dn, mc, fb, fbv);
            chk("x_vec", xv0, xv); chk("busy", busy0, bz); chk("done", done0, dn);
            chk("mismatch_cnt", mc0, mc); chk("first_bad", fb0, fb);
            chk("first_bad_valid", fbv0, fbv); chk("equiv", eq0, dn == 1 && mc == 0);
            model(3, run3, t3, m3, xv, bz, dn, mc, fb, fbv);
            chk("x_vec_s3", xv3, xv); chk("busy_s3", busy3, bz); chk("done_s3", done3, dn);
            chk("mismatch_cnt_s3", mc3, mc); chk("first_bad_s3", fb3, fb);
            chk("first_bad_valid_s3", fbv3, fbv); chk("equiv_s3", eq3, dn == 1 && mc == 0);
        end
    end

    int seq[$];

    task automatic run(input bit which, input int m, input bit restart, output int n);
        @(negedge clk);
        mode = m;
        if (which) start3 = 1; else start0 = 1;
        @(negedge clk);
        start0 = 0; start3 = 0;
        n = 0;
        seq.delete();
        while (!(which ? done3 : done0) && n < 100) begin
            seq.push_back(int'(xv0));
            @(negedge clk);
            n++;
            if (restart && n == 2) start0 = 1;
            else start0 = 0;
        end
        if (n >= 100) chk("done_timeout", n, 0);
    endtask

    initial begin
        int n;
        int exp_seq[7] = '{0, 0, 1, 1, 2, 2, 3};
        repeat (2) @(negedge clk);
        reset = 0;
        chk_en = 1;
        chk("rst_x_vec", xv0, 0); chk("rst_done", done0, 0); chk("rst_busy", busy0, 0);
        chk("rst_cnt", mc0, 0); chk("rst_equiv", eq0, 0); chk("rst_fbv", fbv0, 0);

        run(0, 0, 0, n);
        chk("t1_latency", n, 8); chk("t1_cnt", mc0, 0); chk("t1_equiv", eq0, 1);
        chk("t1_fbv", fbv0, 0);
        for (int i = 0; i < 7; i++) chk("t1_xseq", seq[i], exp_seq[i]);

        run(0, 1, 0, n);
        chk("t2_cnt", mc0, 2); chk("t2_fb", fb0, 1); chk("t2_fbv", fbv0, 1); chk("t2_equiv", eq0, 0);

        run(0, 2, 0, n);
        chk("t3_cnt", mc0, 4); chk("t3_fb", fb0, 0); chk("t3_fbv", fbv0, 1);
        repeat (3) @(negedge clk);
        chk("t3_hold_done", done0, 1); chk("t3_hold_cnt", mc0, 4);

        run(0, 1, 1, n);
        chk("t4_latency", n, 8); chk("t4_cnt", mc0, 2);

        @(negedge clk);
        mode = 2; start0 = 1;
        @(negedge clk);
        start0 = 0;
        repeat (4) @(negedge clk);
        chk("t5_midrun_busy", busy0, 1);
        reset = 1;
        @(negedge clk);
        reset = 0;
        chk("t5_rst_busy", busy0, 0); chk("t5_rst_x", xv0, 0); chk("t5_rst_cnt", mc0, 0);
        chk("t5_rst_fbv", fbv0, 0); chk("t5_rst_done", done0, 0);
        run(0, 0, 0, n);
        chk("t5_latency", n, 8); chk("t5_equiv", eq0, 1);

        run(1, 1, 0, n);
        chk("t6_latency", n, 16); chk("t6_cnt", mc3, 2); chk("t6_fb", fb3, 1);

`ifdef EQUIV_XCHECK_EN
        run(0, 3, 0, n);
        chk("t7_cnt", mc0, 1); chk("t7_fb", fb0, 2);
`endif
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/expr_equiv_checker.md
Name: expr_equiv_checker

Overview:
- Sequential stimulus-and-check stage for 2-input Boolean expression modules of the fxy kind (outputs s1, s2 from inputs x, y).
- Sits upstream, driving the input vector, and downstream, consuming both outputs.
- On start, steps through every input combination, waits a settle window, and compares s1 against s2.
- Reports mismatch count, first failing vector and an equivalence flag.

Parameters:
- N_IN, 2: number of expression inputs; 2^N_IN vectors per run; range 1..8.
- SETTLE, 1: cycles the vector is held before sampling; minimum 1.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  begin a run; sampled in IDLE or DONE only.
- x_vec  output  N_IN  vector driven to the expression under test; x_vec[1]=x, x_vec[0]=y for N_IN=2.
- s1  input  1  first expression output.
- s2  input  1  second expression output.
- busy  output  1  high in SETTLE and SAMPLE.
- done  output  1  high in DONE; held until the next start or reset.
- equiv  output  1  mismatch_cnt==0; meaningful only while done=1.
- mismatch_cnt  output  N_IN+1  number of vectors where s1!=s2; saturates at 2^N_IN.
- first_bad  output  N_IN  x_vec of the first mismatch in the run.
- first_bad_valid  output  1  first_bad holds a captured vector.

Behaviour:
- Reset values: state IDLE, x_vec=0, busy=0, done=0, equiv=0, mismatch_cnt=0, first_bad=0, first_bad_valid=0, settle counter 0.
- Reset has priority over every event, including mid-run; the run is abandoned and no partial result is kept.
- FSM states: IDLE, SETTLE, SAMPLE, DONE.
- IDLE, start=1: next edge enters SETTLE. At the same edge x_vec=0, mismatch_cnt=0, first_bad=0, first_bad_valid=0, settle counter=SETTLE-1.
- SETTLE: x_vec held stable. Counter decrements each edge. At counter 0 the next edge enters SAMPLE. Occupies exactly SETTLE cycles.
- SAMPLE, one cycle: s1 and s2 are compared in this cycle.
  - If they differ: mismatch_cnt increments (saturating). If first_bad_valid=0, first_bad<=x_vec and first_bad_valid<=1 at the same edge.
  - If x_vec is all ones: next state is DONE and x_vec keeps its last value.
  - Otherwise: x_vec<=x_vec+1, counter reloads to SETTLE-1, next state is SETTLE.
- DONE: done=1, busy=0; results are held stable.
  - start=1 restarts exactly as from IDLE, and done drops at that edge.
- start is ignored while busy=1. It is level-sampled, not edge-detected, so holding it high in DONE reruns continuously.
- Latency: done rises 2^N_IN*(SETTLE+1) cycles after the edge that samples start. With defaults, 8 cycles.
- Width rule: mismatch_cnt is N_IN+1 bits, so the all-mismatch case (2^N_IN) fits without wrap.
- x_vec never wraps within a run; the increment from all ones is suppressed.
- equiv is combinational from mismatch_cnt, gated by done.

Optional Feature:
- Macro: EQUIV_XCHECK_EN.
- Defined: SAMPLE counts a mismatch if s1 or s2 is X/Z (case-inequality, simulation-only path), or if s1!=s2.
- Undefined: plain logical inequality, synthesizable. An X on s1/s2 follows normal X-propagation into the comparison.

Decomposition:
- Shared package eqchk_pkg holds:
  - state enum (IDLE, SETTLE, SAMPLE, DONE);
  - default constants N_IN_DEF=2 and SETTLE_DEF=1.
- One natural sub-module, vec_sequencer: x_vec counter plus settle counter, emitting sample_pulse and last_vec.
- The top holds the FSM, comparison and result registers.

Test Plan:
- Defaults, s1=x&~(~x|~y), s2=x&y, start pulse -> done after 8 cycles, equiv=1, mismatch_cnt=0, first_bad_valid=0; x_vec visits 00,01,10,11.
- s1=x&y, s2=x|y -> mismatch_cnt=2, first_bad=01, first_bad_valid=1, equiv=0.
- s1=1, s2=0 -> mismatch_cnt=4 (all vectors, no wrap), first_bad=00.
- start re-asserted at cycle 3 of a run -> ignored; done still at cycle 8. reset at cycle 5 -> all outputs at reset values next edge; a new start completes normally.
- SETTLE=3 -> done 16 cycles after start; x_vec stable for 4 cycles per vector.
- EQUIV_XCHECK_EN defined, s1 driven 1'bx at vector 10, s2=x&y -> mismatch_cnt=1, first_bad=10. Without the macro this case is not required to count.
